// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit scheduler.
//   state_t          : scheduler FSM state encoding
//   DEF_ADDR_TXDATA  : default UART send-data register address
//   DEF_ADDR_CTRL    : default UART control register address
//   DEF_START_VAL    : default control value that kicks off a transmission
package uart_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WR_DATA   = 2'd1,
    ST_WR_START  = 2'd2,
    ST_WAIT_DONE = 2'd3
  } state_t;

  localparam logic [2:0] DEF_ADDR_TXDATA = 3'd1;
  localparam logic [2:0] DEF_ADDR_CTRL   = 3'd0;
  localparam logic [7:0] DEF_START_VAL   = 8'h01;

endpackage

// File: rtl/uart_rr_arbiter.sv
// Combinational round-robin selector.
//   req        : request vector, one bit per requester
//   last_grant : index granted most recently; search starts one above it
//   winner     : first requesting index after last_grant (wrapping)
//   any        : at least one request is set
module uart_rr_arbiter #(
  parameter int N_REQ = 4
) (
  input  logic [N_REQ-1:0]         req,
  input  logic [$clog2(N_REQ)-1:0] last_grant,
  output logic [$clog2(N_REQ)-1:0] winner,
  output logic                     any
);

  localparam int IW = $clog2(N_REQ);

  int            idx;
  logic [IW-1:0] pos;

  // Walk offsets from farthest to nearest so the nearest requester after
  // last_grant is the one left in winner.
  always_comb begin
    winner = '0;
    any    = |req;
    idx    = 0;
    pos    = '0;
    for (int off = N_REQ; off >= 1; off--) begin
      idx = int'(last_grant) + off;
      if (idx >= N_REQ) idx = idx - N_REQ;
      pos = IW'(idx);
      if (req[pos]) winner = pos;
    end
  end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Round-robin byte scheduler feeding a register-mapped UART transmitter.
// Each granted byte is written to the send-data register, the transmission is
// started through the control register, and the block then waits for a
// rising edge on tx_done (or a timeout) before granting again.
//
// Ports
//   clk, rst           : clock, asynchronous active-low reset
//   sched_en           : allow new grants (an in-flight byte always finishes)
//   req_valid/req_data : per-requester byte offers, byte i at [8i+7:8i]
//   req_ready          : accept strobe for the granted requester
//   uart_enable, uart_write_enable, uart_address, uart_write_data : UART bus
//   tx_done            : UART transmit-done level (may stay high many cycles)
//   busy               : scheduler not idle
//   grant_id           : requester owning the in-flight byte
//   timeout_err        : one-cycle pulse when a transmission is abandoned
//   sent_count         : completed transmissions, wraps at 16 bits
//
// Handshake: a byte moves when req_valid[i] and req_ready[i] are both 1 in the
// same cycle. req_ready is combinational, high only in IDLE, only for the
// round-robin winner, and only while sched_en is 1. A requester may drop
// req_valid at any time before that cycle without consequence.
module uart_tx_scheduler
  import uart_pkg::*;
#(
  parameter int         N_REQ          = 4,
  parameter logic [2:0] ADDR_TXDATA    = DEF_ADDR_TXDATA,
  parameter logic [2:0] ADDR_CTRL      = DEF_ADDR_CTRL,
  parameter logic [7:0] START_VAL      = DEF_START_VAL,
  parameter int         TIMEOUT_CYCLES = 1_000_000
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     sched_en,
  input  logic [N_REQ-1:0]         req_valid,
  input  logic [8*N_REQ-1:0]       req_data,
  output logic [N_REQ-1:0]         req_ready,
  output logic                     uart_enable,
  output logic                     uart_write_enable,
  output logic [2:0]               uart_address,
  output logic [7:0]               uart_write_data,
  input  logic                     tx_done,
  output logic                     busy,
  output logic [$clog2(N_REQ)-1:0] grant_id,
  output logic                     timeout_err,
  output logic [15:0]              sent_count
);

  localparam int            IW        = $clog2(N_REQ);
  localparam int            TW        = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [IW-1:0] LAST_INIT = IW'(N_REQ - 1);

  state_t        state;
  logic [IW-1:0] last_grant;
  logic [7:0]    data_q;
  logic [TW-1:0] tmo_cnt;
  logic          done_q;

  logic [IW-1:0] winner;
  logic          any;
  logic          accept;
  logic          done_rise;
  logic [7:0]    win_data;

  uart_rr_arbiter #(.N_REQ(N_REQ)) u_arb (
    .req        (req_valid),
    .last_grant (last_grant),
    .winner     (winner),
    .any        (any)
  );

  // rst is included so req_ready stays 0 while reset is held.
  assign accept    = rst && (state == ST_IDLE) && sched_en && any;
  // A level already high on WAIT_DONE entry has done_q=1 and never qualifies.
  assign done_rise = tx_done && !done_q;
  assign busy      = (state != ST_IDLE);

  always_comb begin
    win_data = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (winner == IW'(i)) win_data = req_data[8*i +: 8];
    end
  end

  always_comb begin
    req_ready = '0;
    if (accept) req_ready[winner] = 1'b1;
  end

  // Bus outputs are a decode of the state register and the latched byte.
  always_comb begin
    uart_enable       = 1'b0;
    uart_write_enable = 1'b0;
    uart_address      = '0;
    uart_write_data   = '0;
    case (state)
      ST_WR_DATA: begin
        uart_enable       = 1'b1;
        uart_write_enable = 1'b1;
        uart_address      = ADDR_TXDATA;
        uart_write_data   = data_q;
      end
      ST_WR_START: begin
        uart_enable       = 1'b1;
        uart_write_enable = 1'b1;
        uart_address      = ADDR_CTRL;
        uart_write_data   = START_VAL;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= ST_IDLE;
      last_grant  <= LAST_INIT;
      grant_id    <= '0;
      data_q      <= '0;
      sent_count  <= '0;
      tmo_cnt     <= '0;
      done_q      <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      done_q      <= tx_done;
      timeout_err <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            data_q     <= win_data;
            last_grant <= winner;
            grant_id   <= winner;
            state      <= ST_WR_DATA;
          end
        end
        ST_WR_DATA: state <= ST_WR_START;
        ST_WR_START: begin
          tmo_cnt <= '0;
          state   <= ST_WAIT_DONE;
        end
        ST_WAIT_DONE: begin
          // Completion is checked first so it wins a tie with the timeout.
          if (done_rise) begin
            sent_count <= sent_count + 16'd1;
            state      <= ST_IDLE;
          end else if (tmo_cnt == TMO_LAST) begin
            timeout_err <= 1'b1;
            state       <= ST_IDLE;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Directed bench for uart_tx_scheduler (N_REQ=4, TIMEOUT_CYCLES=16).
module tb_uart_tx_scheduler;

  localparam int N_REQ = 4;
  localparam int TMO   = 16;

  logic                 clk       = 1'b0;
  logic                 rst       = 1'b0;
  logic                 sched_en  = 1'b0;
  logic                 tx_done   = 1'b0;
  logic [N_REQ-1:0]     req_valid = '0;
  logic [8*N_REQ-1:0]   req_data  = '0;
  logic [N_REQ-1:0]     req_ready;
  logic                 uart_enable;
  logic                 uart_write_enable;
  logic [2:0]           uart_address;
  logic [7:0]           uart_write_data;
  logic                 busy;
  logic [1:0]           grant_id;
  logic                 timeout_err;
  logic [15:0]          sent_count;

  int cyc   = 0;
  int n_vec = 0;
  int n_err = 0;
  logic [7:0] exp_q[$];

  uart_tx_scheduler #(.N_REQ(N_REQ), .TIMEOUT_CYCLES(TMO)) dut (
    .clk               (clk),
    .rst               (rst),
    .sched_en          (sched_en),
    .req_valid         (req_valid),
    .req_data          (req_data),
    .req_ready         (req_ready),
    .uart_enable       (uart_enable),
    .uart_write_enable (uart_write_enable),
    .uart_address      (uart_address),
    .uart_write_data   (uart_write_data),
    .tx_done           (tx_done),
    .busy              (busy),
    .grant_id          (grant_id),
    .timeout_err       (timeout_err),
    .sent_count        (sent_count)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic do_reset();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    n_err++;
    $fatal(1, "watchdog expired");
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Bus scoreboard: every send-data write must match the next expected byte.
  always @(negedge clk) begin
    #1;
    if (uart_enable && uart_write_enable) begin
      if (uart_address == 3'd1) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL bus_unexpected: data write %02h with no byte expected", uart_write_data);
        end else begin
          check("bus_txdata", {24'd0, uart_write_data}, {24'd0, exp_q.pop_front()});
        end
      end else begin
        check("bus_start", {21'd0, uart_address, uart_write_data}, {21'd0, 3'd0, 8'h01});
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Called at a falling edge; returns at +1 of the cycle where req_ready is seen.
  task automatic wait_accept(output int who, output int at);
    who = -1;
    at  = -1;
    for (int k = 0; k < 40; k++) begin
      #1;
      if (|req_ready) begin
        check("ready_onehot", $countones(req_ready), 1);
        for (int i = N_REQ - 1; i >= 0; i--) if (req_ready[i]) who = i;
        at = cyc;
        return;
      end
      @(negedge clk);
    end
    n_vec++;
    n_err++;
    $display("FAIL accept_wait: no req_ready within 40 cycles (cycle %0d)", cyc);
  endtask

  task automatic pulse_done();
    tx_done = 1'b1;
    @(negedge clk);
    tx_done = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int who, at, prev, bad;

    // Reset: outputs quiet even with live requests and tx_done high
    rst = 1'b0; sched_en = 1'b1; req_valid = 4'b1111; req_data = 32'h44332211; tx_done = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    check("rst_ready", {28'd0, req_ready}, 0);
    check("rst_busy", {31'd0, busy}, 0);
    check("rst_bus", {19'd0, uart_enable, uart_write_enable, uart_address, uart_write_data}, 0);
    check("rst_grant_id", {30'd0, grant_id}, 0);
    check("rst_timeout", {31'd0, timeout_err}, 0);
    check("rst_sent", {16'd0, sent_count}, 0);
    @(negedge clk);
    rst = 1'b1; req_valid = '0; sched_en = 1'b0; tx_done = 1'b0; req_data = '0;

    // Single byte from requester 2
    @(negedge clk);
    sched_en = 1'b1; req_valid = 4'b0100; req_data[23:16] = 8'hA5;
    wait_accept(who, at);
    check("t1_ready", {28'd0, req_ready}, 32'b0100);
    check("t1_busy_idle", {31'd0, busy}, 0);
    exp_q.push_back(8'hA5);
    @(negedge clk);
    req_valid = '0;
    #1;
    check("t1_wrdata_strobes", {30'd0, uart_enable, uart_write_enable}, 2'b11);
    check("t1_wrdata_addr", {29'd0, uart_address}, 1);
    check("t1_grant_id", {30'd0, grant_id}, 2);
    check("t1_busy", {31'd0, busy}, 1);
    @(negedge clk);
    #1;
    check("t1_wrstart_addr", {29'd0, uart_address}, 0);
    check("t1_wrstart_data", {24'd0, uart_write_data}, 8'h01);
    @(negedge clk);
    #1;
    check("t1_wait_bus", {19'd0, uart_enable, uart_write_enable, uart_address, uart_write_data}, 0);
    check("t1_wait_busy", {31'd0, busy}, 1);
    pulse_done();
    #1;
    check("t1_sent", {16'd0, sent_count}, 1);
    check("t1_busy_end", {31'd0, busy}, 0);

    // Fairness: all requesters held valid, tx_done 5 cycles after WR_START
    do_reset();
    sched_en = 1'b1; req_valid = 4'b1111; req_data = 32'h13121110;
    prev = 0;
    for (int g = 0; g < 5; g++) begin
      wait_accept(who, at);
      check("t2_order", who, g % 4);
      if (g > 0) check("t2_spacing", at - prev, 8);
      prev = at;
      exp_q.push_back(8'h10 + 8'(g % 4));
      if (g == 4) begin
        @(negedge clk);
        req_valid = '0;
        repeat (6) @(negedge clk);
      end else begin
        repeat (7) @(negedge clk);
      end
      pulse_done();
    end
    #1;
    check("t2_sent", {16'd0, sent_count}, 5);

    // Timeout with tx_done low, then the next requester is served
    req_valid = 4'b0110; req_data = 32'h00221100;
    wait_accept(who, at);
    check("t3_first", who, 1);
    exp_q.push_back(8'h11);
    bad = 0;
    for (int k = 1; k <= 18; k++) begin
      @(negedge clk);
      if (k == 1) req_valid = 4'b0100;
      #1;
      if (timeout_err) bad++;
    end
    check("t3_early_pulse", bad, 0);
    @(negedge clk);
    #1;
    check("t3_timeout_err", {31'd0, timeout_err}, 1);
    check("t3_busy", {31'd0, busy}, 0);
    check("t3_sent_kept", {16'd0, sent_count}, 5);
    check("t3_next_ready", {28'd0, req_ready}, 32'b0100);
    exp_q.push_back(8'h22);
    @(negedge clk);
    req_valid = '0;
    #1;
    check("t3_pulse_width", {31'd0, timeout_err}, 0);
    repeat (2) @(negedge clk);
    pulse_done();
    #1;
    check("t3_sent_after", {16'd0, sent_count}, 6);

    // Stale done: tx_done high before accept and across WAIT_DONE entry
    tx_done = 1'b1; req_valid = 4'b1000; req_data = 32'h3C000000;
    wait_accept(who, at);
    check("t4_winner", who, 3);
    exp_q.push_back(8'h3C);
    @(negedge clk);
    req_valid = '0;
    repeat (5) @(negedge clk);
    #1;
    check("t4_still_busy", {31'd0, busy}, 1);
    check("t4_sent_kept", {16'd0, sent_count}, 6);
    tx_done = 1'b0;
    @(negedge clk);
    pulse_done();
    #1;
    check("t4_sent", {16'd0, sent_count}, 7);
    check("t4_idle", {31'd0, busy}, 0);

    // sched_en gating and dropped request
    sched_en = 1'b0; req_valid = 4'b0001; req_data = 32'h000000C1;
    bad = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      #1;
      if (|req_ready || busy) bad++;
    end
    check("t5_blocked", bad, 0);
    @(negedge clk);
    req_valid = '0; sched_en = 1'b1;
    #1;
    check("t5_dropped_ready", {28'd0, req_ready}, 0);
    @(negedge clk);
    #1;
    check("t5_dropped_busy", {31'd0, busy}, 0);
    req_valid = 4'b0001;
    wait_accept(who, at);
    check("t5_winner", who, 0);
    exp_q.push_back(8'hC1);
    @(negedge clk);
    sched_en = 1'b0; req_valid = 4'b0010;
    repeat (2) @(negedge clk);
    pulse_done();
    #1;
    check("t5_sent", {16'd0, sent_count}, 8);
    check("t5_no_new_grant", {28'd0, req_ready}, 0);
    @(negedge clk);
    #1;
    check("t5_stays_idle", {31'd0, busy}, 0);
    req_valid = '0;

    // Reset mid-flight, then priority restarts at 0 and minimum spacing
    sched_en = 1'b1; req_valid = 4'b0100; req_data = 32'h00770000;
    wait_accept(who, at);
    check("t6_winner", who, 2);
    exp_q.push_back(8'h77);
    @(negedge clk);
    req_valid = 4'b1111; req_data = 32'h44332211;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    check("t6_ready", {28'd0, req_ready}, 0);
    check("t6_busy", {31'd0, busy}, 0);
    check("t6_bus", {19'd0, uart_enable, uart_write_enable, uart_address, uart_write_data}, 0);
    check("t6_grant_id", {30'd0, grant_id}, 0);
    check("t6_sent", {16'd0, sent_count}, 0);
    bad = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      #1;
      if (timeout_err || busy || uart_enable || (|req_ready)) bad++;
    end
    check("t6_hold_quiet", bad, 0);
    @(negedge clk);
    rst = 1'b1;
    wait_accept(who, at);
    check("t6_first_after_rst", who, 0);
    exp_q.push_back(8'h11);
    prev = at;
    repeat (3) @(negedge clk);
    pulse_done();
    wait_accept(who, at);
    check("t6_second", who, 1);
    check("t6_min_spacing", at - prev, 4);
    exp_q.push_back(8'h22);
    @(negedge clk);
    req_valid = '0;
    repeat (2) @(negedge clk);
    pulse_done();
    #1;
    check("t6_sent_after", {16'd0, sent_count}, 2);

    // Wrap of sent_count
    @(negedge clk);
    force dut.sent_count = 16'hFFFF;
    @(negedge clk);
    release dut.sent_count;
    req_valid = 4'b0001; req_data = 32'h000000E7;
    wait_accept(who, at);
    check("t7_winner", who, 0);
    exp_q.push_back(8'hE7);
    @(negedge clk);
    req_valid = '0;
    repeat (2) @(negedge clk);
    pulse_done();
    #1;
    check("t7_wrap", {16'd0, sent_count}, 0);
    check("t7_idle", {31'd0, busy}, 0);

    repeat (2) @(negedge clk);
    check("bus_pending", exp_q.size(), 0);

    // ---------------- report ----------------
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
